// File: rtl/framebuf_reader_pkg.sv
// Shared display definitions: default raster size, RGB444 pixel width and
// the frame-fetch FSM state encoding.
package framebuf_reader_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int PIX_W        = 12;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_FETCH = 2'd1;
    localparam logic [1:0] ENC_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = ENC_IDLE,
        ST_FETCH = ENC_FETCH,
        ST_DRAIN = ENC_DRAIN
    } fb_state_e;

endpackage

// File: rtl/framebuf_reader_rd_valid_pipe.sv
// Tracks outstanding memory reads: tail_o is the read strobe delayed by DEPTH
// cycles, i.e. high exactly when the memory data for that read is valid.
module rd_valid_pipe
    import framebuf_reader_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic i_p_clk,
    input  logic i_rstn,
    input  logic vld_i,
    output logic tail_o
);

    logic [DEPTH-1:0] pipe_q;
    logic [DEPTH-1:0] pipe_d;

    generate
        if (DEPTH == 1) begin : g_one
            assign pipe_d = vld_i;
        end else begin : g_many
            assign pipe_d = {pipe_q[DEPTH-2:0], vld_i};
        end
    endgenerate

    always_ff @(posedge i_p_clk) begin
        if (!i_rstn) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tail_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/framebuf_reader.sv
// Reads one active frame per request from fixed-latency memory into the pixel FIFO.
// Reads issue combinationally while almost-full is low; issued reads are always written.
module framebuf_reader
    import framebuf_reader_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = PIX_W,
    parameter int RD_LATENCY = 2
) (
    input  logic              i_p_clk,
    input  logic              i_rstn,
    input  logic              i_req,
    input  logic              i_buf_sel,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_data,
    output logic              o_wr,
    output logic [DATA_W-1:0] o_wdata,
    input  logic              i_almost_full,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_req_drop
);

    localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE;
    localparam int CNT_W       = $clog2(FRAME_WORDS + 1);

    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(FRAME_WORDS - 1);
    localparam logic [CNT_W-1:0]  ALL_WORDS = CNT_W'(FRAME_WORDS);
    localparam logic [ADDR_W-1:0] BUF1_BASE = ADDR_W'(FRAME_WORDS);

    fb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  issue_q, issue_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              drop_q, drop_d;
    logic              rd;
    logic              rd_tail;

    rd_valid_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_rd_valid_pipe (
        .i_p_clk (i_p_clk),
        .i_rstn  (i_rstn),
        .vld_i   (rd),
        .tail_o  (rd_tail)
    );

    always_ff @(posedge i_p_clk) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            issue_q <= '0;
            wcnt_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            issue_q <= issue_d;
            wcnt_q  <= wcnt_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        issue_d = issue_q;
        wcnt_d  = wcnt_q;
        drop_d  = drop_q;
        rd      = 1'b0;
        // Data returning from memory is written unconditionally one cycle later.
        wr_d    = rd_tail;
        wdata_d = rd_tail ? i_mem_data : wdata_q;
        done_d  = rd_tail && (wcnt_q == LAST_IDX);
        if (rd_tail) begin
            wcnt_d = wcnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (i_req) begin
                    state_d = ST_FETCH;
                    base_d  = i_buf_sel ? BUF1_BASE : '0;
                    issue_d = '0;
                    wcnt_d  = '0;
                end
            end
            ST_FETCH: begin
                rd = !i_almost_full;
                if (rd) begin
                    issue_d = issue_q + CNT_W'(1);
                    if (issue_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (wcnt_q == ALL_WORDS) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Includes the final write cycle: the FSM is still in DRAIN there.
        if (i_req && (state_q != ST_IDLE)) begin
            drop_d = 1'b1;
        end
    end

    assign o_mem_rd     = rd;
    assign o_mem_addr   = base_q + ADDR_W'(issue_q);
    assign o_wr         = wr_q;
    assign o_wdata      = wdata_q;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_frame_done = done_q;
    assign o_req_drop   = drop_q;

endmodule

// File: doc/framebuf_reader.md
# framebuf_reader

Frame-buffer read engine feeding the display path's pixel FIFO. On each per-frame request pulse from the display interface, issued at the last pixel of the blanking period, it reads one full active frame of 12-bit RGB words from a fixed-latency on-chip frame memory. It writes them in raster order into the FIFO the display interface drains, throttled by the FIFO's almost-full flag. It also selects between two frame buffers for double buffering.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- ADDR_W, 20, memory word-address width; must hold 2*H_ACTIVE*V_ACTIVE-1
- DATA_W, 12, pixel width, {R[3:0],G[3:0],B[3:0]}
- RD_LATENCY, 2, memory cycles from o_mem_rd to i_mem_data valid (>=1)

Ports:
- i_p_clk  in  1  pixel clock; all logic on rising edge
- i_rstn  in  1  reset, synchronous, active-low
- i_req  in  1  one-cycle frame-fetch request
- i_buf_sel  in  1  buffer to read, sampled only on an accepted i_req
- o_mem_rd  out  1  memory read strobe
- o_mem_addr  out  ADDR_W  memory word address
- i_mem_data  in  DATA_W  read data, valid exactly RD_LATENCY cycles after o_mem_rd
- o_wr  out  1  FIFO write strobe
- o_wdata  out  DATA_W  FIFO write data
- i_almost_full  in  1  FIFO has <= RD_LATENCY+1 free entries
- o_busy  out  1  frame fetch in progress
- o_frame_done  out  1  one-cycle pulse with the last pixel's o_wr
- o_req_drop  out  1  sticky: an i_req arrived while busy; cleared only by reset

## Operation
- FRAME_WORDS = H_ACTIVE*V_ACTIVE. Base = i_buf_sel ? FRAME_WORDS : 0, latched on accept.
- States:
  - IDLE: i_req -> FETCH. Latch base, clear issue counter. Set o_busy next cycle.
  - FETCH: o_mem_rd = !i_almost_full (combinational). o_mem_addr = base + issue_cnt. issue_cnt increments on each o_mem_rd. The read with issue_cnt == FRAME_WORDS-1 -> DRAIN.
  - DRAIN: no reads. Wait until write counter reaches FRAME_WORDS -> IDLE. o_busy drops the cycle after the last o_wr.
- Read valid: an RD_LATENCY-deep shift register of o_mem_rd. When its tail is 1, i_mem_data is registered into o_wdata and o_wr=1 on the next cycle.
- Writes are never stalled once issued. The almost-full threshold guarantees room for all in-flight reads.
- i_req outside IDLE is ignored and sets o_req_drop. The current frame is not restarted.
- i_req in the same cycle the FSM returns to IDLE (last o_wr cycle) is dropped. A new request must arrive with o_busy=0.
- Counters are ceil(log2(FRAME_WORDS+1)) bits and never wrap within a frame. Address addition is ADDR_W-bit unsigned.

## Timing
- Reset values: o_mem_rd 0, o_mem_addr 0, o_wr 0, o_wdata 0, o_busy 0, o_frame_done 0, o_req_drop 0. State IDLE, pipeline cleared.
- Reset mid-frame: in-flight reads are discarded and no further o_wr occurs. Flushing the FIFO is the system's responsibility.
- First o_mem_rd: one cycle after i_req if i_almost_full=0.
- o_mem_rd to o_wr: RD_LATENCY+1 cycles.
- Unstalled frame: i_req to o_frame_done = FRAME_WORDS + RD_LATENCY + 1 cycles.
- Throughput: one pixel per cycle while i_almost_full=0.
- i_almost_full deasserting resumes reads in the same cycle.

## Structure
- Shared display package: H_ACTIVE/V_ACTIVE defaults, the RGB444 pixel width, and the state encoding localparams (IDLE, FETCH, DRAIN).
- One sub-module, `rd_valid_pipe`: a parameterised RD_LATENCY-deep valid shift register with synchronous clear. Everything else is flat.

## Test plan
Bench uses H_ACTIVE=8, V_ACTIVE=4, RD_LATENCY=2, and a memory model returning data = address.
- Basic fetch: i_req with i_buf_sel=0, FIFO never full -> 32 o_wr with o_wdata 0..31 in order. o_frame_done coincides with o_wdata=31, 35 cycles after i_req. o_busy falls next cycle.
- Buffer select: i_req with i_buf_sel=1 -> o_mem_addr 32..63 and o_wdata 32..63.
- Back-pressure: hold i_almost_full=1 for 10 cycles mid-frame -> o_mem_rd=0 throughout. At most 3 further o_wr occur after assertion. Data stays contiguous with no loss or duplication.
- Request while busy: second i_req at cycle 5 -> o_req_drop=1 and stays 1. Exactly 32 writes occur.
- Reset mid-frame: i_rstn=0 for one cycle after 10 reads -> all outputs 0 next cycle and no o_wr afterwards. A following i_req fetches a clean frame from address 0.
- Back-to-back frames: i_req one cycle after o_busy falls -> second frame completes identically to the first, o_req_drop=0.
